// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch front end: PC register, PCSrc redirect, single-outstanding
// instruction-memory request/response handshake and fetch-stall reporting.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0004,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_pc,
    input  logic [2:0]  pc_src,
    input  logic [31:0] alu_target,
    input  logic [31:0] jump_target,
    input  logic [31:0] xepc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        stall_fetch
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        PC_NEXT        = 3'd0,
        PC_BRANCH_ALU  = 3'd1,
        PC_BRANCH_JUMP = 3'd2,
        PC_XEPC        = 3'd3,
        PC_TRAP        = 3'd4
    } pc_src_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic        kill, kill_d;
    logic [31:0] held, held_d;

    logic [31:0] target_raw;
    logic [31:0] target;
    logic        redirect;
    logic        avail;
    logic        outstanding;

    // Encodings 5..7 fall through to the sequential path
    always_comb begin
        redirect   = 1'b0;
        target_raw = pc + 32'd4;
        case (pc_src)
            PC_BRANCH_ALU: begin
                redirect   = 1'b1;
                target_raw = alu_target;
            end
            PC_BRANCH_JUMP: begin
                redirect   = 1'b1;
                target_raw = jump_target;
            end
            PC_XEPC: begin
                redirect   = 1'b1;
                target_raw = xepc;
            end
            PC_TRAP: begin
                redirect   = 1'b1;
                target_raw = TRAP_VEC;
            end
            default: ;
        endcase
        target = {target_raw[31:2], 2'b00};
    end

    assign avail       = (state == S_HOLD) || ((state == S_WAIT) && imem_rvalid && !kill);
    assign outstanding = ((state == S_WAIT) && !imem_rvalid) || ((state == S_REQ) && imem_gnt);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        kill_d  = kill;
        held_d  = held;

        case (state)
            S_REQ: begin
                if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        held_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: ;
            default: state_d = S_REQ;
        endcase

        // PC update overrides the handshake progress; a still-pending response
        // for the old PC must be swallowed before a new request may issue
        if (en_pc && redirect) begin
            pc_d    = target;
            kill_d  = outstanding;
            state_d = outstanding ? S_WAIT : S_REQ;
        end else if (en_pc && avail) begin
            pc_d    = target;
            state_d = S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            held  <= NOP_INSTR;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            kill  <= kill_d;
            held  <= held_d;
        end
    end

    // Reset state is S_REQ, so the request is masked while reset is held
    assign imem_req    = rst_n && (state == S_REQ);
    assign imem_addr   = pc;
    assign if_pc       = pc;
    assign stall_fetch = !avail;
    assign if_instr    = (state == S_HOLD) ? held : (avail ? imem_rdata : NOP_INSTR);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized bench for if_fetch_ctrl: epoch-based fetch model feeding an
// instruction scoreboard, plus per-cycle checks of PC, request and stall.
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0004;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam int unsigned NCYC      = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_pc = 1'b0;
    logic [2:0]  pc_src = 3'd0;
    logic [31:0] alu_target = '0;
    logic [31:0] jump_target = '0;
    logic [31:0] xepc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall_fetch;

    if_fetch_ctrl #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_pc      (en_pc),
        .pc_src     (pc_src),
        .alu_target (alu_target),
        .jump_target(jump_target),
        .xepc       (xepc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_pc      (if_pc),
        .if_instr   (if_instr),
        .stall_fetch(stall_fetch)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    // Architectural model: every PC change opens a new epoch; a response is
    // usable only if its request was granted in the current epoch.
    logic [31:0] m_pc = RESET_PC;
    bit          m_have = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int unsigned pend_ep = 0;
    int unsigned pend_cnt = 0;
    int unsigned epoch = 0;
    bit          late = 1'b0;

    bit          p_en = 1'b0;
    logic [2:0]  p_src = 3'd0;
    logic [31:0] p_alu = '0, p_jmp = '0, p_xepc = '0;
    bit          p_gnt = 1'b0;
    logic [31:0] p_gnt_addr = '0;
    bit          p_rv_real = 1'b0, p_rv_ok = 1'b0, p_avail = 1'b0;

    logic [31:0] e_pc = RESET_PC;
    bit          e_avail = 1'b0;
    bit          e_req = 1'b0;

    int unsigned en_pct = 20, redir_pct = 10, gnt_pct = 60, max_lat = 3;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0050_0093;
    endfunction

    function automatic bit is_redirect(input logic [2:0] s);
        return (s >= 3'd1) && (s <= 3'd4);
    endfunction

    function automatic logic [31:0] redirect_target(input logic [2:0] s, input logic [31:0] a,
                                                    input logic [31:0] j, input logic [31:0] x);
        logic [31:0] t;
        case (s)
            3'd1:    t = a;
            3'd2:    t = j;
            3'd3:    t = x;
            default: t = TRAP_VEC;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(4, 0))
            0:       return 32'hFFFF_FFFC;
            1:       return 32'hFFFF_FFF9;
            2:       return 32'h0000_0080;
            3:       return 32'h0000_0103;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Applies the effects of the previous cycle at the clock edge
    task automatic model_advance();
        bit changed;
        changed = 1'b0;
        if (p_en && is_redirect(p_src)) begin
            m_pc    = redirect_target(p_src, p_alu, p_jmp, p_xepc);
            changed = 1'b1;
        end else if (p_en && p_avail) begin
            m_pc    = m_pc + 32'd4;
            changed = 1'b1;
        end
        if (p_rv_real) pend = 1'b0;
        if (p_rv_ok) m_have = 1'b1;
        if (p_gnt) begin
            pend      = 1'b1;
            pend_addr = p_gnt_addr;
            pend_ep   = epoch;
            pend_cnt  = $urandom_range(max_lat, 1);
        end
        if (changed) begin
            epoch++;
            m_have = 1'b0;
        end
    endtask

    // Drives this cycle's inputs and publishes the model's expectations
    task automatic drive_cycle();
        bit rv, rv_real, rv_ok, gnt, en;
        logic [2:0] src;
        logic [31:0] rd, a, j, x;
        exp_t e;
        rv = 1'b0; rv_real = 1'b0; rv_ok = 1'b0;
        rd = $urandom;
        if (late) begin
            rv   = 1'b1;
            rd   = 32'hDEAD_BEEF;
            late = 1'b0;
        end else if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                rv      = 1'b1;
                rv_real = 1'b1;
                rd      = mem_word(pend_addr);
                rv_ok   = (pend_ep == epoch);
            end
        end
        gnt = imem_req && !pend && ($urandom_range(99, 0) < gnt_pct);
        en  = ($urandom_range(99, 0) < en_pct);
        if ($urandom_range(99, 0) < redir_pct) src = 3'($urandom_range(4, 1));
        else if ($urandom_range(3, 0) == 0) src = 3'($urandom_range(7, 5));
        else src = 3'd0;
        a = pick_target();
        j = pick_target();
        x = pick_target();

        en_pc = en; pc_src = src; alu_target = a; jump_target = j; xepc = x;
        imem_gnt = gnt; imem_rvalid = rv; imem_rdata = rd;

        e_avail = m_have || rv_ok;
        e_req   = !pend && !m_have;
        e_pc    = m_pc;
        if (rv_ok && !m_have) begin
            e.pc    = m_pc;
            e.instr = mem_word(m_pc);
            exp_q.push_back(e);
        end

        p_en = en; p_src = src; p_alu = a; p_jmp = j; p_xepc = x;
        p_gnt = gnt; p_gnt_addr = imem_addr;
        p_rv_real = rv_real; p_rv_ok = rv_ok; p_avail = e_avail;
    endtask

    // Reset pulse while a granted request is still awaiting its response
    task automatic mid_reset();
        en_pc = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_stall", 32'(stall_fetch), 32'd1);
        check("rst_if_instr", if_instr, NOP_INSTR);
        check("rst_if_pc", if_pc, RESET_PC);
        m_pc = RESET_PC; m_have = 1'b0; pend = 1'b0; epoch++; late = 1'b1;
        e_pc = RESET_PC; e_avail = 1'b0; e_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin : monitor
        bit prev_stall;
        exp_t cur;
        int unsigned stall_run;
        prev_stall = 1'b1;
        cur        = '0;
        stall_run  = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("if_pc", if_pc, e_pc);
            check("stall_fetch", 32'(stall_fetch), 32'(!e_avail));
            check("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) check("imem_addr", imem_addr, e_pc);
            if (!e_avail) check("if_instr_nop", if_instr, NOP_INSTR);
            if (!stall_fetch) begin
                if (prev_stall) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL present: got pc %h instr %h, expected no instruction", if_pc, if_instr);
                    end else begin
                        cur = exp_q.pop_front();
                        check("present_pc", if_pc, cur.pc);
                        check("present_instr", if_instr, cur.instr);
                    end
                end else begin
                    check("held_instr", if_instr, cur.instr);
                end
                stall_run = 0;
            end else if (rst_n) begin
                stall_run++;
                if (stall_run > 100) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL stall_timeout: got %0d stalled cycles, required <= 100", stall_run);
                    stall_run = 0;
                end
            end
            prev_stall = stall_fetch;
        end
    end

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_cycle();
        for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 1000) begin
                en_pct = 70; redir_pct = 40; gnt_pct = 50; max_lat = 3;
            end else if (cyc == 2000) begin
                en_pct = 50; redir_pct = 25; gnt_pct = 90; max_lat = 1;
            end
            @(posedge clk);
            #1;
            model_advance();
            if (((cyc > 700 && cyc < 760) || (cyc > 1500 && cyc < 1560) || (cyc > 2500 && cyc < 2560))
                && pend && (cyc % 4 == 0)) begin
                mid_reset();
            end
            drive_cycle();
        end
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
